// File: rtl/fpu_result_wb.sv
// FPU result writeback stage: formats each FPU result, buffers it in a small
// FIFO with valid/ready on both sides, and owns the architectural fflags
// (sticky) and frm registers.
module fpu_result_wb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_result_i,
  input  logic [4:0]      in_flags_i,
  input  logic            in_cmp_i,
  input  logic            in_is_cmp_i,
  input  logic            in_is_sp_i,
  input  logic            in_to_int_i,
  input  logic [4:0]      in_rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic [4:0]      out_rd_o,
  output logic            out_to_int_o,
  input  logic            flush_i,
  input  logic            csr_we_i,
  input  logic [1:0]      csr_sel_i,
  input  logic [7:0]      csr_wdata_i,
  output logic [7:0]      csr_rdata_o,
  output logic [2:0]      frm_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic             to_int_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Architectural CSR state
  logic [4:0] fflags_q, fflags_d;
  logic [2:0] frm_q, frm_d;

  logic            enq;
  logic            deq;
  logic            wr_en;
  logic [XLEN-1:0] fmt_data;

  // Result formatting applied before the entry is stored
  always_comb begin
    fmt_data = in_result_i;
    if (in_is_cmp_i) begin
      fmt_data = {{(XLEN-1){1'b0}}, in_cmp_i};
    end else if (in_to_int_i) begin
      fmt_data = {{(XLEN-32){in_result_i[31]}}, in_result_i[31:0]};
    end else if (in_is_sp_i) begin
      fmt_data = {{(XLEN-32){1'b1}}, in_result_i[31:0]};
    end
  end

  // Handshakes: no full-bypass, so in_ready depends only on the stored count
  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;
  // A flush drops the incoming entry; its flags are still accumulated below
  assign wr_en       = enq && !flush_i;

  // Pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_W'(1);
      if (deq)   rptr_d = rptr_q + PTR_W'(1);
      case ({wr_en, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // CSR next-state: writes and newly raised flags both take effect
  always_comb begin
    fflags_d = fflags_q;
    frm_d    = frm_q;
    if (csr_we_i && csr_sel_i[0]) fflags_d = csr_wdata_i[4:0];
    if (enq)                      fflags_d = fflags_d | in_flags_i;
    if (csr_we_i && csr_sel_i == 2'b10) frm_d = csr_wdata_i[2:0];
    if (csr_we_i && csr_sel_i == 2'b11) frm_d = csr_wdata_i[7:5];
  end

  // Control and CSR registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero when empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]   <= '0;
        rd_q[i]     <= '0;
        to_int_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      data_q[wptr_q]   <= fmt_data;
      rd_q[wptr_q]     <= in_rd_i;
      to_int_q[wptr_q] <= in_to_int_i;
    end
  end

  // Head entry is always presented straight from the registered storage
  assign out_data_o   = data_q[rptr_q];
  assign out_rd_o     = rd_q[rptr_q];
  assign out_to_int_o = to_int_q[rptr_q];

  // CSR read mux, zero-extended to the fcsr width
  always_comb begin
    csr_rdata_o = '0;
    case (csr_sel_i)
      2'b01:   csr_rdata_o = {3'b000, fflags_q};
      2'b10:   csr_rdata_o = {5'b00000, frm_q};
      2'b11:   csr_rdata_o = {frm_q, fflags_q};
      default: csr_rdata_o = '0;
    endcase
  end

  assign frm_o = frm_q;

endmodule

// File: tb/tb_fpu_result_wb.sv
// Directed test of the FPU writeback stage: formatting, FIFO ordering and
// backpressure, sticky flags, frm/fcsr access, flush and async reset.
module tb_fpu_result_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_flags;
  logic        in_cmp;
  logic        in_is_cmp;
  logic        in_is_sp;
  logic        in_to_int;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_to_int;
  logic        flush;
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [7:0]  csr_wdata;
  logic [7:0]  csr_rdata;
  logic [2:0]  frm;

  int total = 0;
  int bad   = 0;
  logic [7:0] rv;

  fpu_result_wb #(.DEPTH(2), .XLEN(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_result_i  (in_result),
    .in_flags_i   (in_flags),
    .in_cmp_i     (in_cmp),
    .in_is_cmp_i  (in_is_cmp),
    .in_is_sp_i   (in_is_sp),
    .in_to_int_i  (in_to_int),
    .in_rd_i      (in_rd),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_rd_o     (out_rd),
    .out_to_int_o (out_to_int),
    .flush_i      (flush),
    .csr_we_i     (csr_we),
    .csr_sel_i    (csr_sel),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .frm_o        (frm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_csr(input logic [1:0] sel, output logic [7:0] val);
    csr_sel = sel;
    #1;
    val = csr_rdata;
  endtask

  // Present one result for the coming edge (caller ticks)
  task automatic drive(input logic [63:0] res, input logic [4:0] flg, input logic cmp,
                       input logic is_cmp, input logic is_sp, input logic to_int,
                       input logic [4:0] rd);
    in_valid  = 1'b1;
    in_result = res;
    in_flags  = flg;
    in_cmp    = cmp;
    in_is_cmp = is_cmp;
    in_is_sp  = is_sp;
    in_to_int = to_int;
    in_rd     = rd;
    $display("push rd=%0d res=%h flags=%b ready=%b", rd, res, flg, in_ready);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_flags  = 5'b0;
    in_cmp    = 1'b0;
    in_is_cmp = 1'b0;
    in_is_sp  = 1'b0;
    in_to_int = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_cmp = 1'b0;
    in_is_cmp = 1'b0; in_is_sp = 1'b0; in_to_int = 1'b0; in_rd = '0;
    out_ready = 1'b0; flush = 1'b0; csr_we = 1'b0; csr_sel = 2'b11; csr_wdata = '0;
    tick(); tick();
    // Reset state
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_rd", 64'(out_rd), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_frm", 64'(frm), 64'd0);
    rd_csr(2'b11, rv);
    check_val("rst_fcsr", 64'(rv), 64'd0);
    rst_n = 1'b1;
    tick();

    // FP64 result passes through unchanged, flags become sticky
    drive(64'h3FF0000000000000, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    tick(); idle();
    check_val("fp64_valid", 64'(out_valid), 64'd1);
    check_val("fp64_data", out_data, 64'h3FF0000000000000);
    check_val("fp64_rd", 64'(out_rd), 64'd3);
    rd_csr(2'b01, rv);
    check_val("fp64_fflags", 64'(rv), 64'h01);
    out_ready = 1'b1;
    tick();
    check_val("fp64_drained", 64'(out_valid), 64'd0);

    // FP32 result is NaN-boxed
    drive(64'h1234567840490FDB, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
    tick(); idle();
    check_val("sp_data", out_data, 64'hFFFFFFFF40490FDB);
    check_val("sp_to_int", 64'(out_to_int), 64'd0);
    tick();

    // Compare result is the single flag bit
    drive(64'hDEADBEEFCAFEF00D, 5'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5);
    tick(); idle();
    check_val("cmp_data", out_data, 64'h1);
    check_val("cmp_to_int", 64'(out_to_int), 64'd1);
    tick();

    // Integer conversions are sign-extended from bit 31
    drive(64'hDEADBEEF80000000, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick(); idle();
    check_val("cvt_neg_data", out_data, 64'hFFFFFFFF80000000);
    tick();
    drive(64'hFFFFFFFF7FFFFFFF, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
    tick(); idle();
    check_val("cvt_pos_data", out_data, 64'h000000007FFFFFFF);
    tick();

    // Clear fflags, then fill the FIFO under backpressure
    csr_we = 1'b1; csr_sel = 2'b01; csr_wdata = 8'h00;
    tick();
    csr_we = 1'b0;
    out_ready = 1'b0;
    drive(64'hAAAA000000000001, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10);
    tick();
    check_val("full_ready_1", 64'(in_ready), 64'd1);
    drive(64'hBBBB000000000002, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11);
    tick();
    check_val("full_ready_2", 64'(in_ready), 64'd0);
    drive(64'hCCCC000000000003, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12);
    tick(); idle();
    check_val("full_ready_3", 64'(in_ready), 64'd0);
    check_val("full_head_a", out_data, 64'hAAAA000000000001);
    check_val("full_head_rd", 64'(out_rd), 64'd10);
    rd_csr(2'b01, rv);
    check_val("full_fflags", 64'(rv), 64'h02);
    out_ready = 1'b1;
    tick();
    check_val("drain_head_b", out_data, 64'hBBBB000000000002);
    check_val("drain_valid_b", 64'(out_valid), 64'd1);
    check_val("drain_ready_b", 64'(in_ready), 64'd1);
    tick();
    check_val("drain_empty", 64'(out_valid), 64'd0);

    // Simultaneous enqueue and dequeue with one entry held
    out_ready = 1'b0;
    drive(64'h0000000000000D0D, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13);
    tick();
    out_ready = 1'b1;
    drive(64'h0000000000000E0E, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14);
    tick(); idle();
    check_val("simul_valid", 64'(out_valid), 64'd1);
    check_val("simul_data", out_data, 64'h0000000000000E0E);
    check_val("simul_ready", 64'(in_ready), 64'd1);
    tick();
    check_val("simul_empty", 64'(out_valid), 64'd0);

    // fcsr write coincident with an enqueue raising NV
    csr_we = 1'b1; csr_sel = 2'b11; csr_wdata = 8'hE0;
    drive(64'h4000000000000000, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
    tick(); idle();
    csr_we = 1'b0;
    check_val("fcsr_frm", 64'(frm), 64'd7);
    rd_csr(2'b11, rv);
    check_val("fcsr_rdata", 64'(rv), 64'hF0);
    rd_csr(2'b01, rv);
    check_val("fcsr_fflags", 64'(rv), 64'h10);
    tick();

    // frm-only write stores reserved values; selector 00 is ignored
    csr_we = 1'b1; csr_sel = 2'b10; csr_wdata = 8'hFD;
    tick();
    csr_we = 1'b0;
    check_val("frm_write", 64'(frm), 64'd5);
    rd_csr(2'b10, rv);
    check_val("frm_rdata", 64'(rv), 64'h05);
    csr_we = 1'b1; csr_sel = 2'b00; csr_wdata = 8'hFF;
    tick();
    csr_we = 1'b0;
    check_val("sel00_frm", 64'(frm), 64'd5);
    rd_csr(2'b00, rv);
    check_val("sel00_rdata", 64'(rv), 64'h00);
    rd_csr(2'b01, rv);
    check_val("sel00_fflags", 64'(rv), 64'h10);

    // Flush with one entry held and a dropped enqueue
    out_ready = 1'b0;
    drive(64'h000000000000F00F, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16);
    tick();
    flush = 1'b1;
    drive(64'h0000000000001111, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd17);
    tick(); idle();
    flush = 1'b0;
    check_val("flush_valid", 64'(out_valid), 64'd0);
    check_val("flush_ready", 64'(in_ready), 64'd1);
    rd_csr(2'b01, rv);
    check_val("flush_fflags", 64'(rv), 64'h18);
    check_val("flush_frm", 64'(frm), 64'd5);
    drive(64'h0000000000002222, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd18);
    tick(); idle();
    check_val("post_flush_data", out_data, 64'h0000000000002222);
    check_val("post_flush_rd", 64'(out_rd), 64'd18);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_data", out_data, 64'd0);
    check_val("arst_frm", 64'(frm), 64'd0);
    rd_csr(2'b11, rv);
    check_val("arst_fcsr", 64'(rv), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
